// File: rtl/sbox_out_collect_pkg.sv
// Shared constants and types for the S-box output collection path.
// Imported by the collector top and the masked column FIFO.
package sbox_out_collect_pkg;

    localparam int SBOX_LAT   = 4;
    localparam int SBOX_LANES = 4;
    localparam int COL_BITS   = 32;
    localparam int TAG_W      = 2;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/msk_col_fifo.sv
// Share-wise register FIFO for masked columns plus a plain tag sideband.
// Entries are individual registers; the head is selected by pointer only.
module msk_col_fifo #(
    parameter int d     = 2,
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int TW    = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic [W*d-1:0]               push_data,
    input  logic [TW-1:0]                push_tag,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         full,
    output logic                         empty,
    output logic [W*d-1:0]               head_data,
    output logic [TW-1:0]                head_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             wr_en;
    logic             rd_en;

    logic [W*d-1:0]   ent_data [DEPTH];
    logic [TW-1:0]    ent_tag  [DEPTH];

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);
    assign occ   = occ_q;

    // A push into a full buffer is discarded so stored columns stay intact.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (rd_en) begin
            head_d = (head_q == PTR_W'(DEPTH-1)) ? '0 : head_q + PTR_W'(1);
        end
        if (wr_en) begin
            tail_d = (tail_q == PTR_W'(DEPTH-1)) ? '0 : tail_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [W*d-1:0] data_q, data_d;
            logic [TW-1:0]  tag_q, tag_d;
            logic           we;

            assign we = wr_en && (tail_q == PTR_W'(gi));

            always_comb begin
                data_d = data_q;
                tag_d  = tag_q;
                if (we) begin
                    data_d = push_data;
                    tag_d  = push_tag;
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    data_q <= '0;
                    tag_q  <= '0;
                end else begin
                    data_q <= data_d;
                    tag_q  <= tag_d;
                end
            end

            assign ent_data[gi] = data_q;
            assign ent_tag[gi]  = tag_q;
        end
    endgenerate

    assign head_data = ent_data[head_q];
    assign head_tag  = ent_tag[head_q];

endmodule

// File: rtl/sbox_out_collect.sv
// Tracks S-box evaluations through the fixed-latency pipeline, buffers the masked
// result columns, and grants issue credit only when storage is guaranteed.
module sbox_out_collect
    import sbox_out_collect_pkg::*;
#(
    parameter int d     = 2,
    parameter int LAT   = SBOX_LAT,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    syncrst,
    input  logic                    in_issue,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    issue_ok,
    input  logic [COL_BITS*d-1:0]   sb_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COL_BITS*d-1:0]   out_col,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    err
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(DEPTH+LAT+1);

    logic [LAT-1:0] vld_pipe_q, vld_pipe_d;
    tag_t           tag_pipe_q [LAT];
    tag_t           tag_pipe_d [LAT];
    logic           err_q, err_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] committed;

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = in_issue;
        for (int i = 0; i < LAT; i++) begin
            tag_pipe_d[i] = tag_pipe_q[i];
        end
        tag_pipe_d[0] = in_tag;
        for (int i = 1; i < LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    assign push = vld_pipe_q[LAT-1];
    assign pop  = out_valid & out_ready;

    // Credit counts every column already stored or still in the S-box pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
    end

    assign committed = CNT_W'(occ) + inflight;
    assign issue_ok  = (committed < CNT_W'(DEPTH));

    always_comb begin
        err_d = err_q;
        if ((in_issue && !issue_ok) || (push && fifo_full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (syncrst) begin
            vld_pipe_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            vld_pipe_q <= vld_pipe_d;
            err_q      <= err_d;
            for (int i = 0; i < LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_d[i];
            end
        end
    end

    msk_col_fifo #(
        .d     (d),
        .DEPTH (DEPTH),
        .W     (COL_BITS),
        .TW    (TAG_W)
    ) u_fifo (
        .clk       (clk),
        .srst      (syncrst),
        .push      (push),
        .push_data (sb_out),
        .push_tag  (tag_pipe_q[LAT-1]),
        .pop       (pop),
        .occ       (occ),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (out_col),
        .head_tag  (out_tag)
    );

    assign out_valid = ~fifo_empty;
    assign err       = err_q;

endmodule
